// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - ISR codes, RX trigger levels and character-length helper for the UART
package uart_pkg;

    localparam logic [3:0] ISR_NONE = 4'b0001;
    localparam logic [3:0] ISR_RLS  = 4'b0110;
    localparam logic [3:0] ISR_RDA  = 4'b0100;
    localparam logic [3:0] ISR_CTO  = 4'b1100;
    localparam logic [3:0] ISR_THRE = 4'b0010;
    localparam logic [3:0] ISR_MS   = 4'b0000;

    localparam int RX_TRIG_1  = 1;
    localparam int RX_TRIG_4  = 4;
    localparam int RX_TRIG_8  = 8;
    localparam int RX_TRIG_14 = 14;

    // Start + data + parity + stop bits; ranges 7..12.
    function automatic logic [3:0] char_bits(input logic [3:0] lcr);
        return 4'd1 + (4'd5 + {2'b00, lcr[1:0]}) + {3'b000, lcr[3]} + (lcr[2] ? 4'd2 : 4'd1);
    endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// rtl/uart_rx_timeout.sv - RX character-timeout counter and flag
module uart_rx_timeout
    import uart_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       bit_tick_i,
    input  logic [3:0] lcr_i,
    input  logic       enable,
    input  logic       restart,
    input  logic       level_nz,
    output logic       timeout_o
);

    logic [5:0] cnt_q, cnt_d;
    logic [5:0] limit;
    logic       flag_q, flag_d;

    assign limit = {char_bits(lcr_i), 2'b00};

    always_comb begin
        cnt_d = cnt_q;
        if (restart || !level_nz || !enable) begin
            cnt_d = '0;
        end else if (cnt_q >= limit) begin
            // Also pulls the count back down when LCR shrinks the limit mid-count.
            cnt_d = limit;
        end else if (bit_tick_i) begin
            cnt_d = cnt_q + 6'd1;
        end

        flag_d = flag_q;
        if (cnt_q >= limit && level_nz) begin
            flag_d = 1'b1;
        end
        if (restart || !level_nz) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    // Next-state view so the registered ISR sees the flag with a single cycle of latency.
    assign timeout_o = flag_d;

endmodule

// File: rtl/uart_interrupt_ctrl.sv
// rtl/uart_interrupt_ctrl.sv - 16550 interrupt source tracking, IER masking and ISR priority encode
module uart_interrupt_ctrl
    import uart_pkg::*;
#(
    parameter int FifoDepth  = 16,
    parameter int LevelWidth = $clog2(FifoDepth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [3:0]            ier_i,
    input  logic                  fcr_fifo_en_i,
    input  logic [1:0]            fcr_rx_trig_i,
    input  logic [3:0]            lcr_i,
    input  logic                  bit_tick_i,
    input  logic                  rx_push_i,
    input  logic                  rx_pop_i,
    input  logic [LevelWidth-1:0] rx_level_i,
    input  logic                  lsr_err_i,
    input  logic                  tx_empty_i,
    input  logic                  thr_write_i,
    input  logic                  isr_read_i,
    input  logic [3:0]            msr_delta_i,
    output logic [7:0]            isr_o,
    output logic                  isr_valid_o,
    output logic                  irq_o
);

    logic erbi, etbei, elsi, edssi;
    logic level_nz, to_flag;
    logic [LevelWidth-1:0] trig;
    logic rls, rda, cto, ms;
    logic thre_flag_q, thre_flag_d, thre_edge_q, ier1_q;
    logic thre_set, thre_top, thre_next;
    logic [3:0] code;
    logic [7:0] isr_q, isr_d;
    logic irq_q;

    assign erbi     = ier_i[0];
    assign etbei    = ier_i[1];
    assign elsi     = ier_i[2];
    assign edssi    = ier_i[3];
    assign level_nz = (rx_level_i != '0);

    uart_rx_timeout u_rx_timeout (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .bit_tick_i (bit_tick_i),
        .lcr_i      (lcr_i),
        .enable     (fcr_fifo_en_i),
        .restart    (rx_push_i | rx_pop_i),
        .level_nz   (level_nz),
        .timeout_o  (to_flag)
    );

    always_comb begin
        trig = LevelWidth'(RX_TRIG_1);
        if (fcr_fifo_en_i) begin
            unique case (fcr_rx_trig_i)
                2'd0:    trig = LevelWidth'(RX_TRIG_1);
                2'd1:    trig = LevelWidth'(RX_TRIG_4);
                2'd2:    trig = LevelWidth'(RX_TRIG_8);
                default: trig = LevelWidth'(RX_TRIG_14);
            endcase
        end
    end

    assign rls = elsi & lsr_err_i;
    assign rda = erbi & (rx_level_i >= trig);
    assign cto = erbi & fcr_fifo_en_i & to_flag;
    assign ms  = edssi & (|msr_delta_i);

    // THRE rearms on an empty edge or when ETBEI is newly enabled over an empty THR.
    assign thre_set = tx_empty_i & (~thre_edge_q | (etbei & ~ier1_q));
    assign thre_top = etbei & thre_flag_q & ~rls & ~rda & ~cto;

    always_comb begin
        thre_flag_d = thre_flag_q;
        if (isr_read_i && thre_top) thre_flag_d = 1'b0;
        if (thre_set)               thre_flag_d = 1'b1;
        if (thr_write_i)            thre_flag_d = 1'b0;
    end

    assign thre_next = etbei & thre_flag_d;

    always_comb begin
        code = ISR_NONE;
        if (rls)            code = ISR_RLS;
        else if (rda)       code = ISR_RDA;
        else if (cto)       code = ISR_CTO;
        else if (thre_next) code = ISR_THRE;
        else if (ms)        code = ISR_MS;
        isr_d = {{2{fcr_fifo_en_i}}, 2'b00, code};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            isr_q       <= {4'h0, ISR_NONE};
            irq_q       <= 1'b0;
            thre_flag_q <= 1'b0;
            thre_edge_q <= 1'b1;
            ier1_q      <= 1'b0;
        end else begin
            isr_q       <= isr_d;
            irq_q       <= ~isr_d[0];
            thre_flag_q <= thre_flag_d;
            thre_edge_q <= tx_empty_i;
            ier1_q      <= ier_i[1];
        end
    end

    assign isr_o       = isr_q;
    assign irq_o       = irq_q;
    assign isr_valid_o = 1'b1;

endmodule

// File: tb/tb_uart_interrupt_ctrl.sv
// tb/tb_uart_interrupt_ctrl.sv - directed self-checking bench for uart_interrupt_ctrl
module tb_uart_interrupt_ctrl;

    localparam int FifoDepth  = 16;
    localparam int LevelWidth = $clog2(FifoDepth + 1);

    logic                  clk = 1'b0;
    logic                  rst_ni;
    logic [3:0]            ier;
    logic                  fifo_en;
    logic [1:0]            rx_trig;
    logic [3:0]            lcr;
    logic                  bit_tick, rx_push, rx_pop;
    logic [LevelWidth-1:0] rx_level;
    logic                  lsr_err, tx_empty, thr_write, isr_read;
    logic [3:0]            msr_delta;
    logic [7:0]            isr;
    logic                  isr_valid, irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_interrupt_ctrl #(.FifoDepth(FifoDepth)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .ier_i         (ier),
        .fcr_fifo_en_i (fifo_en),
        .fcr_rx_trig_i (rx_trig),
        .lcr_i         (lcr),
        .bit_tick_i    (bit_tick),
        .rx_push_i     (rx_push),
        .rx_pop_i      (rx_pop),
        .rx_level_i    (rx_level),
        .lsr_err_i     (lsr_err),
        .tx_empty_i    (tx_empty),
        .thr_write_i   (thr_write),
        .isr_read_i    (isr_read),
        .msr_delta_i   (msr_delta),
        .isr_o         (isr),
        .isr_valid_o   (isr_valid),
        .irq_o         (irq)
    );

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bit_tick = 1'b1;
            cyc(1);
            bit_tick = 1'b0;
            cyc(2);
        end
    endtask

    task automatic push_one(input int new_level);
        rx_push = 1'b1;
        cyc(1);
        rx_push  = 1'b0;
        rx_level = LevelWidth'(new_level);
        cyc(1);
    endtask

    initial begin
        rst_ni = 1'b0; ier = 4'h0; fifo_en = 1'b0; rx_trig = 2'b00; lcr = 4'h3;
        bit_tick = 1'b0; rx_push = 1'b0; rx_pop = 1'b0; rx_level = '0;
        lsr_err = 1'b0; tx_empty = 1'b0; thr_write = 1'b0; isr_read = 1'b0; msr_delta = 4'h0;
        cyc(2);
        chk("reset_isr", isr, 8'h01);
        chk("reset_irq", {7'b0, irq}, 8'h00);
        chk("reset_valid", {7'b0, isr_valid}, 8'h01);
        rst_ni = 1'b1;
        cyc(2);
        chk("idle_isr", isr, 8'h01);

        // RX data available at trigger level 4
        ier = 4'b0001; fifo_en = 1'b1; rx_trig = 2'b01;
        cyc(1);
        chk("fifo_idle", isr, 8'hC1);
        for (int i = 1; i <= 3; i++) push_one(i);
        chk("rda_level3", isr, 8'hC1);
        push_one(4);
        chk("rda_level4", isr, 8'hC4);
        chk("rda_irq", {7'b0, irq}, 8'h01);
        rx_pop = 1'b1;
        cyc(1);
        rx_pop = 1'b0; rx_level = LevelWidth'(3);
        cyc(1);
        chk("rda_pop", isr, 8'hC1);
        rx_level = '0;
        cyc(1);

        // Character timeout, 8N1 -> 40 ticks
        push_one(1);
        chk("cto_start", isr, 8'hC1);
        ticks(39);
        chk("cto_tick39", isr, 8'hC1);
        ticks(1);
        chk("cto_tick40", isr, 8'hCC);
        rx_pop = 1'b1;
        cyc(1);
        chk("cto_pop", isr, 8'hC1);
        rx_pop = 1'b0; rx_level = '0;
        cyc(1);

        // Limit shrinks below current count: 8E2 (48) -> 5N1 (28) at count 30
        lcr = 4'hF;
        push_one(1);
        ticks(30);
        chk("lcr_long", isr, 8'hC1);
        lcr = 4'h0;
        cyc(2);
        chk("lcr_shrink", isr, 8'hCC);
        rx_pop = 1'b1;
        cyc(1);
        rx_pop = 1'b0; rx_level = '0; lcr = 4'h3;
        cyc(1);

        // Synchronous reset mid-timeout restarts the 40-tick count
        push_one(1);
        ticks(30);
        rst_ni = 1'b0;
        cyc(1);
        chk("midreset_isr", isr, 8'h01);
        rst_ni = 1'b1;
        cyc(1);
        chk("midreset_release", isr, 8'hC1);
        ticks(39);
        chk("midreset_tick39", isr, 8'hC1);
        ticks(1);
        chk("midreset_tick40", isr, 8'hCC);
        rx_pop = 1'b1;
        cyc(1);
        rx_pop = 1'b0; rx_level = '0;
        cyc(1);

        // THRE set, ISR-read clear, precedence
        fifo_en = 1'b0; ier = 4'b0010; tx_empty = 1'b1;
        cyc(1);
        chk("thre_set", isr, 8'h02);
        chk("thre_irq", {7'b0, irq}, 8'h01);
        isr_read = 1'b1;
        cyc(1);
        isr_read = 1'b0;
        chk("thre_read_clr", isr, 8'h01);
        chk("thre_read_irq", {7'b0, irq}, 8'h00);
        ier = 4'b0000;
        cyc(1);
        ier = 4'b0010;
        cyc(1);
        chk("thre_ier_rise", isr, 8'h02);
        tx_empty = 1'b0;
        cyc(1);
        chk("thre_hold", isr, 8'h02);
        tx_empty = 1'b1; isr_read = 1'b1;
        cyc(1);
        isr_read = 1'b0;
        chk("thre_set_over_read", isr, 8'h02);
        thr_write = 1'b1;
        cyc(1);
        thr_write = 1'b0; tx_empty = 1'b0;
        chk("thre_write_clr", isr, 8'h01);
        cyc(1);

        // Priority: RLS > RDA > THRE > MS
        ier = 4'b1111; fifo_en = 1'b1; rx_trig = 2'b00; rx_level = LevelWidth'(1);
        tx_empty = 1'b1; lsr_err = 1'b1; msr_delta = 4'b0001;
        cyc(1);
        chk("prio_rls", isr, 8'hC6);
        lsr_err = 1'b0;
        cyc(1);
        chk("prio_rda", isr, 8'hC4);
        rx_level = '0;
        cyc(1);
        chk("prio_thre", isr, 8'hC2);
        thr_write = 1'b1;
        cyc(1);
        thr_write = 1'b0;
        chk("prio_ms", isr, 8'hC0);
        chk("prio_ms_irq", {7'b0, irq}, 8'h01);
        msr_delta = 4'h0;
        cyc(1);
        chk("prio_none", isr, 8'hC1);

        // Non-FIFO mode ignores trigger select
        fifo_en = 1'b0; rx_trig = 2'b11; ier = 4'b0001; tx_empty = 1'b0; rx_level = LevelWidth'(1);
        cyc(1);
        chk("nonfifo_rda", isr, 8'h04);
        rx_level = '0;
        cyc(1);
        chk("nonfifo_none", isr, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
